sram_arbiter: RTL

- Two-port round-robin arbiter and sequencer for the 64x8 single-port static RAM (ce / rw / 6-bit addr / 8-bit data).
- Accepts independent read/write requests from requesters A and B and serialises them onto the RAM command pins.
- Generates the RAM's read sequence (address-register cycle, then data cycle) and write cycle.
- Returns a one-cycle acknowledge, with read data, to the served requester.

---
 rtl/sram_pkg.sv | 47 ++++
 rtl/sram_arbiter_rr_arbiter2.sv | 97 +++++++++
 rtl/sram_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 64x8 SRAM arbiter slice.
//   - Default RAM geometry (address / data widths).
//   - FSM state encoding used by sram_arbiter.
//   - Requester (owner) encoding and small helper functions.
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int SRAM_ADDR_W = 6;
  localparam int SRAM_DATA_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // Return the requester that is not o.
  function automatic owner_e other_owner(input owner_e o);
    if (o == OWN_A) begin
      return OWN_B;
    end else begin
      return OWN_A;
    end
  endfunction

  // RAM command pins {ce, rw, oe} to present while the FSM sits in state st.
  function automatic logic [2:0] ram_pins(input logic [2:0] st);
    logic [2:0] pins;
    case (st)
      ST_WRITE:   pins = 3'b111;
      ST_RD_ADDR: pins = 3'b100;
      ST_RD_DATA: pins = 3'b010;
      ST_IDLE:    pins = 3'b000;
      ST_DONE:    pins = 3'b000;
      default:    pins = 3'b000;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic for the SRAM arbiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_a/b      : raw requests from requesters A and B
//   i_en           : FSM is idle and can accept a grant this cycle
//   i_done         : FSM is in DONE; arms the stale-owner mask
//   i_owner        : owner of the transaction that is finishing
//   o_gnt          : a grant is issued this cycle (combinational)
//   o_gnt_owner    : which requester is granted (combinational)
// The mask blocks the just-served requester for the single idle cycle that
// follows DONE, because it is still holding req while it reacts to the ack.
// ---------------------------------------------------------------------------
module rr_arbiter2
  import sram_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_req_a,
  input  logic   i_req_b,
  input  logic   i_en,
  input  logic   i_done,
  input  owner_e i_owner,
  output logic   o_gnt,
  output owner_e o_gnt_owner
);

  owner_e ptr_r;
  logic   mask_vld_r;
  owner_e mask_owner_r;
  logic   req_a_s;
  logic   req_b_s;

  // Drop the request of the requester that was served last, while the mask is armed.
  always_comb begin
    req_a_s = i_req_a;
    req_b_s = i_req_b;
    if (mask_vld_r) begin
      if (mask_owner_r == OWN_A) begin
        req_a_s = 1'b0;
      end else begin
        req_b_s = 1'b0;
      end
    end else begin
      req_a_s = i_req_a;
      req_b_s = i_req_b;
    end
  end

  // Grant selection: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    o_gnt       = 1'b0;
    o_gnt_owner = ptr_r;
    if (!i_en) begin
      o_gnt       = 1'b0;
      o_gnt_owner = ptr_r;
    end else if (req_a_s && req_b_s) begin
      o_gnt       = 1'b1;
      o_gnt_owner = ptr_r;
    end else if (req_a_s) begin
      o_gnt       = 1'b1;
      o_gnt_owner = OWN_A;
    end else if (req_b_s) begin
      o_gnt       = 1'b1;
      o_gnt_owner = OWN_B;
    end else begin
      o_gnt       = 1'b0;
      o_gnt_owner = ptr_r;
    end
  end

  // Round-robin pointer: after any grant it names the side that was not served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r <= OWN_A;
    end else if (i_en && o_gnt) begin
      ptr_r <= other_owner(o_gnt_owner);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Stale-owner mask: armed for exactly the cycle after DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_vld_r   <= 1'b0;
      mask_owner_r <= OWN_A;
    end else if (i_done) begin
      mask_vld_r   <= 1'b1;
      mask_owner_r <= i_owner;
    end else begin
      mask_vld_r   <= 1'b0;
      mask_owner_r <= mask_owner_r;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Serialises read/write requests from two requesters onto a 64x8 single-port
// SRAM (ce / rw / addr / data) and returns a one-cycle ack with read data.
//   i_clk, i_rst_n                   : clock, asynchronous active-low reset
//   i_req_x, i_we_x                  : request and op (1 = write) per side
//   i_addr_x, i_wdata_x              : address and write data per side
//   o_ack_x, o_rdata_x               : completion pulse and read data per side
//   o_ram_ce, o_ram_rw, o_ram_oe     : RAM command pins and bus-drive enable
//   o_ram_addr, o_ram_wdata          : RAM address and write data
//   i_ram_rdata                      : RAM data bus as seen by the controller
//   o_busy                           : FSM is not idle
// Every output is a flop loaded from the next-state value, so the RAM pins
// line up with the state the FSM is in.
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  output logic              o_ack_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic              i_req_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_ack_b,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_ram_ce,
  output logic              o_ram_rw,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_oe,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  logic [2:0]        state_r;
  logic [2:0]        nxt_s;
  owner_e            owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              gnt_s;
  owner_e            gnt_owner_s;
  logic              idle_s;
  logic              done_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [2:0]        pins_s;
  logic              ce_r;
  logic              rw_r;
  logic              oe_r;
  logic              ack_a_r;
  logic              ack_b_r;
  logic              busy_r;
  logic [DATA_W-1:0] rdata_a_r;
  logic [DATA_W-1:0] rdata_b_r;

  assign idle_s = (state_r == ST_IDLE);
  assign done_s = (state_r == ST_DONE);

  rr_arbiter2 u_rr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_en        (idle_s),
    .i_done      (done_s),
    .i_owner     (owner_r),
    .o_gnt       (gnt_s),
    .o_gnt_owner (gnt_owner_s)
  );

  // Route the granted requester's operation, address and data.
  always_comb begin
    sel_we_s    = i_we_a;
    sel_addr_s  = i_addr_a;
    sel_wdata_s = i_wdata_a;
    if (gnt_owner_s == OWN_B) begin
      sel_we_s    = i_we_b;
      sel_addr_s  = i_addr_b;
      sel_wdata_s = i_wdata_b;
    end else begin
      sel_we_s    = i_we_a;
      sel_addr_s  = i_addr_a;
      sel_wdata_s = i_wdata_a;
    end
  end

  // Next-state logic; every non-idle state lasts exactly one cycle.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s) begin
          nxt_s = sel_we_s ? ST_WRITE : ST_RD_ADDR;
        end else begin
          nxt_s = ST_IDLE;
        end
      end
      ST_WRITE:   nxt_s = ST_DONE;
      ST_RD_ADDR: nxt_s = ST_RD_DATA;
      ST_RD_DATA: nxt_s = ST_DONE;
      ST_DONE:    nxt_s = ST_IDLE;
      default:    nxt_s = ST_IDLE;
    endcase
  end

  assign pins_s = ram_pins(nxt_s);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_s;
    end
  end

  // Transaction latch: captured only at grant so later request changes are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_r <= OWN_A;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (idle_s && gnt_s) begin
      owner_r <= gnt_owner_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
    end else begin
      owner_r <= owner_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // RAM pins, busy and ack flops, loaded from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ce_r    <= 1'b0;
      rw_r    <= 1'b0;
      oe_r    <= 1'b0;
      busy_r  <= 1'b0;
      ack_a_r <= 1'b0;
      ack_b_r <= 1'b0;
    end else begin
      ce_r    <= pins_s[2];
      rw_r    <= pins_s[1];
      oe_r    <= pins_s[0];
      busy_r  <= (nxt_s != ST_IDLE);
      ack_a_r <= (nxt_s == ST_DONE) && (owner_r == OWN_A);
      ack_b_r <= (nxt_s == ST_DONE) && (owner_r == OWN_B);
    end
  end

  // Read data: sampled from the RAM bus at the end of RD_DATA, held otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_a_r <= {DATA_W{1'b0}};
      rdata_b_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_RD_DATA) begin
      if (owner_r == OWN_A) begin
        rdata_a_r <= i_ram_rdata;
        rdata_b_r <= rdata_b_r;
      end else begin
        rdata_a_r <= rdata_a_r;
        rdata_b_r <= i_ram_rdata;
      end
    end else begin
      rdata_a_r <= rdata_a_r;
      rdata_b_r <= rdata_b_r;
    end
  end

  assign o_ram_ce    = ce_r;
  assign o_ram_rw    = rw_r;
  assign o_ram_oe    = oe_r;
  assign o_ram_addr  = addr_r;
  assign o_ram_wdata = wdata_r;
  assign o_busy      = busy_r;
  assign o_ack_a     = ack_a_r;
  assign o_ack_b     = ack_b_r;
  assign o_rdata_a   = rdata_a_r;
  assign o_rdata_b   = rdata_b_r;

endmodule
